// File: rtl/l2_request_arbiter_pkg.sv
// Shared lc3b memory-hierarchy types plus the L1->L2 arbiter's state and owner encodings.
package l2_request_arbiter_pkg;

  localparam int LC3B_ADDR_W = 16;
  localparam int LC3B_LINE_W = 128;

  typedef logic [LC3B_ADDR_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D,
    ARB_RELEASE
  } lc3b_arb_state;

  typedef enum logic {
    OWN_I,
    OWN_D
  } lc3b_arb_owner;

endpackage

// File: rtl/l2_request_arbiter_l2_req_latch.sv
// Holds the granted request (address, writeback line, op) stable for the whole L2 transaction.
module l2_req_latch
  import l2_request_arbiter_pkg::*;
#(
  parameter int ADDR_W = LC3B_ADDR_W,
  parameter int LINE_W = LC3B_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic              i_write,
  output logic [ADDR_W-1:0] o_address,
  output logic [LINE_W-1:0] o_wdata,
  output logic              o_write
);

  logic [ADDR_W-1:0] r_address;
  logic [LINE_W-1:0] r_wdata;
  logic              r_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_address <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
    end else if (i_load) begin
      r_address <= i_address;
      r_wdata   <= i_wdata;
      r_write   <= i_write;
    end
  end

  assign o_address = r_address;
  assign o_wdata   = r_wdata;
  assign o_write   = r_write;

endmodule

// File: rtl/l2_request_arbiter.sv
// Serialises I-cache and D-cache line requests onto a single L2 port with alternating priority.
module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int ADDR_W = LC3B_ADDR_W,
  parameter int LINE_W = LC3B_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  lc3b_arb_state r_state;
  lc3b_arb_owner r_lastOwner;
  logic              r_l2Read;
  logic              r_l2Write;
  logic              r_iResp;
  logic              r_dResp;
  logic [LINE_W-1:0] r_iRdata;
  logic [LINE_W-1:0] r_dRdata;

  logic              w_iReq;
  logic              w_dReq;
  logic              w_grant;
  logic              w_grantD;
  logic              w_grantWrite;
  logic [ADDR_W-1:0] w_grantAddress;
  logic [LINE_W-1:0] w_grantWdata;
  logic              w_latchWrite;

  assign w_iReq = i_read;
  assign w_dReq = d_read | d_write;
  assign w_grant = (r_state == ARB_IDLE) && (w_iReq || w_dReq);
  // On contention the port that did not win last time gets the L2.
  assign w_grantD = w_dReq && (!w_iReq || (r_lastOwner == OWN_I));
  assign w_grantWrite   = w_grantD & d_write;
  assign w_grantAddress = w_grantD ? d_address : i_address;
  assign w_grantWdata   = w_grantD ? d_wdata : '0;

  l2_req_latch #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) u_reqLatch (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_grant),
    .i_address(w_grantAddress),
    .i_wdata  (w_grantWdata),
    .i_write  (w_grantWrite),
    .o_address(l2_address),
    .o_wdata  (l2_wdata),
    .o_write  (w_latchWrite)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_lastOwner <= OWN_I;
      r_l2Read    <= 1'b0;
      r_l2Write   <= 1'b0;
      r_iResp     <= 1'b0;
      r_dResp     <= 1'b0;
      r_iRdata    <= '0;
      r_dRdata    <= '0;
    end else begin
      r_iResp <= 1'b0;
      r_dResp <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_grant) begin
            r_lastOwner <= w_grantD ? OWN_D : OWN_I;
            r_state     <= w_grantD ? ARB_SERVE_D : ARB_SERVE_I;
            r_l2Read    <= !w_grantWrite;
            r_l2Write   <= w_grantWrite;
          end
        end
        ARB_SERVE_I, ARB_SERVE_D: begin
          if (l2_resp) begin
            r_l2Read  <= 1'b0;
            r_l2Write <= 1'b0;
            r_state   <= ARB_RELEASE;
            if (r_state == ARB_SERVE_I) begin
              r_iResp  <= 1'b1;
              r_iRdata <= w_latchWrite ? '0 : l2_rdata;
            end else begin
              r_dResp  <= 1'b1;
              r_dRdata <= w_latchWrite ? '0 : l2_rdata;
            end
          end
        end
        ARB_RELEASE: r_state <= ARB_IDLE;
        default:     r_state <= ARB_IDLE;
      endcase
    end
  end

  assign l2_read  = r_l2Read;
  assign l2_write = r_l2Write;
  assign i_resp   = r_iResp;
  assign d_resp   = r_dResp;
  assign i_rdata  = r_iRdata;
  assign d_rdata  = r_dRdata;

  // Simultaneous read and writeback from the D-cache is resolved as a write, but is still suspicious.
  assert property (@(posedge clk) disable iff (reset) !(d_read && d_write));
  assert property (@(posedge clk) disable iff (reset) !(l2_read && l2_write));

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: acts as both L1 caches and as the L2, checking each scenario.
module tb_l2_request_arbiter;
  import l2_request_arbiter_pkg::*;

  logic     clk;
  logic     reset;
  logic     i_read;
  lc3b_word i_address;
  lc3b_line i_rdata;
  logic     i_resp;
  logic     d_read;
  logic     d_write;
  lc3b_word d_address;
  lc3b_line d_wdata;
  lc3b_line d_rdata;
  logic     d_resp;
  logic     l2_read;
  logic     l2_write;
  lc3b_word l2_address;
  lc3b_line l2_wdata;
  lc3b_line l2_rdata;
  logic     l2_resp;

  int assertCount = 0;
  int failCount   = 0;

  l2_request_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .i_read    (i_read),
    .i_address (i_address),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_address (d_address),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .l2_read   (l2_read),
    .l2_write  (l2_write),
    .l2_address(l2_address),
    .l2_wdata  (l2_wdata),
    .l2_rdata  (l2_rdata),
    .l2_resp   (l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for the arbiter to raise an L2 request; cycles counts negedges until it appears.
  task automatic waitL2Req(output bit seen, output int cycles);
    seen   = 1'b0;
    cycles = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (l2_read || l2_write) begin
        seen   = 1'b1;
        cycles = k + 1;
        break;
      end
    end
  endtask

  task automatic l2Respond(input int waitCycles, input lc3b_line data);
    repeat (waitCycles) @(negedge clk);
    l2_rdata = data;
    l2_resp  = 1'b1;
    @(negedge clk);
    l2_resp  = 1'b0;
    l2_rdata = '0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    l2_rdata = '0; l2_resp = 1'b0;
    repeat (2) @(negedge clk);
    assertCount++;
    if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {l2_read, l2_write, i_resp, d_resp});
    end
    assertCount++;
    if (l2_address !== 16'h0 || l2_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_data: addr=%h wdata=%h irdata=%h drdata=%h expected all 0",
               l2_address, l2_wdata, i_rdata, d_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_i_read();
    bit seen; int cycles;
    i_read = 1'b1; i_address = 16'h1230;
    waitL2Req(seen, cycles);
    assertCount++;
    if (!seen || cycles != 1) begin
      failCount++;
      $display("[TB] FAIL i_latency: seen=%0d cycles=%0d expected seen=1 cycles=1", seen, cycles);
    end
    assertCount++;
    if (l2_read !== 1'b1 || l2_write !== 1'b0 || l2_address !== 16'h1230) begin
      failCount++;
      $display("[TB] FAIL i_req: rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=1230", l2_read, l2_write, l2_address);
    end
    l2Respond(2, {16{8'hA5}});
    assertCount++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== {16{8'hA5}} || l2_read !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL i_resp: iresp=%b dresp=%b irdata=%h l2rd=%b expected 1 0 a5.. 0",
               i_resp, d_resp, i_rdata, l2_read);
    end
    i_read = 1'b0;
    @(negedge clk);
    assertCount++;
    if (i_resp !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL i_resp_pulse: iresp=%b expected 0", i_resp);
    end
  endtask

  task automatic test_d_write();
    bit seen; int cycles;
    d_write = 1'b1; d_address = 16'h4560;
    d_wdata = 128'h0123456789ABCDEF_FEDCBA9876543210;
    waitL2Req(seen, cycles);
    assertCount++;
    if (!seen || l2_write !== 1'b1 || l2_read !== 1'b0 || l2_address !== 16'h4560 ||
        l2_wdata !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin
      failCount++;
      $display("[TB] FAIL d_write_req: seen=%0d wr=%b rd=%b addr=%h wdata=%h expected 1 1 0 4560 0123..3210",
               seen, l2_write, l2_read, l2_address, l2_wdata);
    end
    l2Respond(1, {32{4'hF}});
    assertCount++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== '0 || i_rdata !== {16{8'hA5}}) begin
      failCount++;
      $display("[TB] FAIL d_write_resp: dresp=%b iresp=%b drdata=%h irdata=%h expected 1 0 0 a5..",
               d_resp, i_resp, d_rdata, i_rdata);
    end
    d_write = 1'b0;
    @(negedge clk);
    assertCount++;
    if (d_resp !== 1'b0 || l2_write !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL d_resp_pulse: dresp=%b l2wr=%b expected 0 0", d_resp, l2_write);
    end
  endtask

  task automatic test_both_from_reset();
    bit seen; int cycles;
    pulseReset();
    i_read = 1'b1; i_address = 16'h2220;
    d_read = 1'b1; d_address = 16'h3330;
    waitL2Req(seen, cycles);
    assertCount++;
    if (!seen || l2_address !== 16'h3330 || l2_read !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL both_first: seen=%0d addr=%h rd=%b expected 1 3330 1", seen, l2_address, l2_read);
    end
    l2Respond(1, {16{8'hD3}});
    assertCount++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== {16{8'hD3}}) begin
      failCount++;
      $display("[TB] FAIL both_d_resp: dresp=%b iresp=%b drdata=%h expected 1 0 d3..", d_resp, i_resp, d_rdata);
    end
    d_read = 1'b0;
    waitL2Req(seen, cycles);
    assertCount++;
    if (!seen || cycles != 2 || l2_address !== 16'h2220) begin
      failCount++;
      $display("[TB] FAIL both_second: seen=%0d cycles=%0d addr=%h expected 1 2 2220", seen, cycles, l2_address);
    end
    l2Respond(0, {16{8'h1C}});
    assertCount++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== {16{8'h1C}} || d_rdata !== {16{8'hD3}}) begin
      failCount++;
      $display("[TB] FAIL both_i_resp: iresp=%b dresp=%b irdata=%h drdata=%h expected 1 0 1c.. d3..",
               i_resp, d_resp, i_rdata, d_rdata);
    end
    i_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit seen; int cycles;
    bit expD;
    lc3b_line data;
    i_read = 1'b1; i_address = 16'h1000;
    d_read = 1'b1; d_address = 16'h2000;
    for (int t = 0; t < 6; t++) begin
      expD = (t % 2 == 0);
      data = {16{8'(8'h10 + t)}};
      waitL2Req(seen, cycles);
      assertCount++;
      if (!seen || l2_address !== (expD ? 16'h2000 : 16'h1000)) begin
        failCount++;
        $display("[TB] FAIL b2b_grant%0d: seen=%0d addr=%h expected %h", t, seen, l2_address,
                 expD ? 16'h2000 : 16'h1000);
      end
      l2Respond(0, data);
      assertCount++;
      if (i_resp !== !expD || d_resp !== expD || (expD ? d_rdata : i_rdata) !== data) begin
        failCount++;
        $display("[TB] FAIL b2b_resp%0d: iresp=%b dresp=%b irdata=%h drdata=%h expected owner=%s data=%h",
                 t, i_resp, d_resp, i_rdata, d_rdata, expD ? "D" : "I", data);
      end
    end
    i_read = 1'b0;
    d_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_serve();
    bit seen; int cycles;
    d_read = 1'b1; d_address = 16'h5550;
    waitL2Req(seen, cycles);
    assertCount++;
    if (!seen || l2_read !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL mid_req: seen=%0d rd=%b expected 1 1", seen, l2_read);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    assertCount++;
    if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0000 || l2_address !== 16'h0 ||
        l2_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
      failCount++;
      $display("[TB] FAIL mid_reset: ctrl=%b addr=%h wdata=%h irdata=%h drdata=%h expected all 0",
               {l2_read, l2_write, i_resp, d_resp}, l2_address, l2_wdata, i_rdata, d_rdata);
    end
    d_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    i_read = 1'b1; i_address = 16'h6660;
    waitL2Req(seen, cycles);
    assertCount++;
    if (!seen || cycles != 1 || l2_address !== 16'h6660 || l2_read !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL post_reset_req: seen=%0d cycles=%0d addr=%h rd=%b expected 1 1 6660 1",
               seen, cycles, l2_address, l2_read);
    end
    l2Respond(1, {16{8'h66}});
    assertCount++;
    if (i_resp !== 1'b1 || i_rdata !== {16{8'h66}}) begin
      failCount++;
      $display("[TB] FAIL post_reset_resp: iresp=%b irdata=%h expected 1 66..", i_resp, i_rdata);
    end
    i_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addr_change_and_stray_resp();
    bit seen; int cycles;
    i_read = 1'b1; i_address = 16'h7770;
    waitL2Req(seen, cycles);
    i_address = 16'h1110;
    @(negedge clk);
    assertCount++;
    if (!seen || l2_address !== 16'h7770 || l2_read !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL addr_hold: seen=%0d addr=%h rd=%b expected 1 7770 1", seen, l2_address, l2_read);
    end
    l2Respond(0, {16{8'h77}});
    assertCount++;
    if (i_resp !== 1'b1 || i_rdata !== {16{8'h77}}) begin
      failCount++;
      $display("[TB] FAIL addr_hold_resp: iresp=%b irdata=%h expected 1 77..", i_resp, i_rdata);
    end
    i_read = 1'b0;
    @(negedge clk);
    l2_rdata = {8{16'hDEAD}};
    l2_resp  = 1'b1;
    @(negedge clk);
    l2_resp  = 1'b0;
    l2_rdata = '0;
    assertCount++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 || l2_read !== 1'b0 || i_rdata !== {16{8'h77}}) begin
      failCount++;
      $display("[TB] FAIL stray_resp: iresp=%b dresp=%b rd=%b irdata=%h expected 0 0 0 77..",
               i_resp, d_resp, l2_read, i_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_i_read();
    test_d_write();
    test_both_from_reset();
    test_back_to_back();
    test_reset_mid_serve();
    test_addr_change_and_stray_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
